// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared types for the stream multiplexer family
package mux_pkg;
   typedef enum logic {MUX_SEL, MUX_RR} mux_mode_e;
endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rtl/stream_mux_rr_arbiter.sv - rotating-priority arbiter: first requester at or after ptr wins
module rr_arbiter #(
   parameter int  N    = 4,
   localparam int SELW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [SELW-1:0] idx
);
   logic [SELW:0]   sum;
   logic [SELW-1:0] jj;

   always_comb begin
      grant = '0;
      idx   = '0;
      sum   = '0;
      jj    = '0;
      // ptr < N and k < N, so one conditional subtract gives (ptr + k) mod N.
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + (SELW+1)'(k);
         if (sum >= (SELW+1)'(N)) sum = sum - (SELW+1)'(N);
         jj = sum[SELW-1:0];
         if (grant == '0 && req[jj]) begin
            grant[jj] = 1'b1;
            idx       = jj;
         end
      end
   end
endmodule

// File: rtl/stream_mux.sv
// rtl/stream_mux.sv - N-way valid/ready mux with a registered output, external select or round-robin
module stream_mux
   import mux_pkg::*;
#(
   parameter int        WIDTH = 32,
   parameter int        N     = 4,
   parameter mux_mode_e MODE  = MUX_SEL,
   localparam int       SELW  = $clog2(N)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [SELW-1:0]    sel,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SELW-1:0]    out_src
);
   logic [N-1:0]     grant;
   logic [SELW-1:0]  grant_idx;
   logic [WIDTH-1:0] grant_data;
   logic             can_load;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic [SELW-1:0]  out_src_q, out_src_d;
   logic [SELW-1:0]  ptr_q, ptr_d;

   generate
      if (MODE == MUX_RR) begin : g_rr
         rr_arbiter #(.N(N)) u_arb (
            .req   (in_valid),
            .ptr   (ptr_q),
            .grant (grant),
            .idx   (grant_idx)
         );
      end else begin : g_sel
         // An out-of-range select matches no channel, so nothing is granted.
         always_comb begin
            grant = '0;
            for (int i = 0; i < N; i++) begin
               if (sel == SELW'(i)) grant[i] = in_valid[i];
            end
         end
         assign grant_idx = sel;
      end
   endgenerate

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) grant_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   assign can_load = !out_valid_q || out_ready;
   assign in_ready = (reset || !can_load) ? '0 : grant;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      ptr_d       = ptr_q;
      if (can_load) begin
         out_valid_d = |grant;
         if (|grant) begin
            out_data_d = grant_data;
            out_src_d  = grant_idx;
            ptr_d      = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_src   = out_src_q;
endmodule
